// File: rtl/object_pkg.sv
// Shared definitions for object_mover: FSM states, HitEdgeCode bit positions
// and the fixed-point scaling used for positions and speeds.
package object_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BOUNCE,
        ACCEL,
        POSITION,
        OUTPUT
    } state_t;

    localparam int HIT_LEFT   = 3;
    localparam int HIT_TOP    = 2;
    localparam int HIT_RIGHT  = 1;
    localparam int HIT_BOTTOM = 0;

    localparam int FIXED_POINT_SHIFT = 6;

endpackage

// File: rtl/object_mover.sv
// Moves an on-screen object once per VGA frame: bounce off touched edges,
// apply gravity or a jump, integrate position, then publish pixel coordinates.
module object_mover
    import object_pkg::*;
#(
    parameter int INITIAL_X       = 280,
    parameter int INITIAL_Y       = 185,
    parameter int INITIAL_X_SPEED = 40,
    parameter int INITIAL_Y_SPEED = 20,
    parameter int Y_ACCEL         = 1,
    parameter int MAX_Y_SPEED     = 230,
    parameter int JUMP_SPEED      = 200
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               collision,
    input  logic [3:0]         HitEdgeCode,
    input  logic               jumpKey,
    output logic signed [10:0] topLeftX,
    output logic signed [10:0] topLeftY
);

    state_t state, next_state;

    logic signed [31:0] pos_x, pos_y;
    logic signed [31:0] speed_x, speed_y;
    logic [3:0]         hit_latch;
    logic               flip_x, flip_y;

    function automatic logic signed [31:0] sat_y_speed(input logic signed [31:0] v);
        if (v > MAX_Y_SPEED)
            return MAX_Y_SPEED;
        else if (v < -MAX_Y_SPEED)
            return -MAX_Y_SPEED;
        else
            return v;
    endfunction

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (startOfFrame) next_state = BOUNCE;
            BOUNCE:   next_state = ACCEL;
            ACCEL:    next_state = POSITION;
            POSITION: next_state = OUTPUT;
            OUTPUT:   next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // A collision arriving while BOUNCE consumes the latch is kept for next frame.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            hit_latch <= 4'b0;
        else if (state == BOUNCE)
            hit_latch <= collision ? HitEdgeCode : 4'b0;
        else if (collision)
            hit_latch <= hit_latch | HitEdgeCode;
    end

    always_comb begin
        flip_x = (hit_latch[HIT_LEFT]  && (speed_x < 0)) ||
                 (hit_latch[HIT_RIGHT] && (speed_x > 0));
        flip_y = (hit_latch[HIT_TOP]    && (speed_y < 0)) ||
                 (hit_latch[HIT_BOTTOM] && (speed_y > 0));
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pos_x    <= INITIAL_X * (1 << FIXED_POINT_SHIFT);
            pos_y    <= INITIAL_Y * (1 << FIXED_POINT_SHIFT);
            speed_x  <= INITIAL_X_SPEED;
            speed_y  <= INITIAL_Y_SPEED;
            topLeftX <= 11'(INITIAL_X);
            topLeftY <= 11'(INITIAL_Y);
        end else begin
            case (state)
                BOUNCE: begin
                    if (flip_x) speed_x <= -speed_x;
                    if (flip_y) speed_y <= -speed_y;
                end
                ACCEL: begin
                    speed_y <= jumpKey ? -JUMP_SPEED : sat_y_speed(speed_y + Y_ACCEL);
                end
                POSITION: begin
                    pos_x <= pos_x + speed_x;
                    pos_y <= pos_y + speed_y;
                end
                OUTPUT: begin
                    // Arithmetic shift floors toward -inf for negative positions.
                    topLeftX <= 11'(pos_x >>> FIXED_POINT_SHIFT);
                    topLeftY <= 11'(pos_y >>> FIXED_POINT_SHIFT);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/object_mover.md
OBJECT_MOVER -- requirements
Module: object_mover

Interface
REQ-001 Parameter INITIAL_X, default 280, meaning initial top-left X in pixels.
REQ-002 Parameter INITIAL_Y, default 185, meaning initial top-left Y in pixels.
REQ-003 Parameter INITIAL_X_SPEED, default 40, meaning initial X speed in fixed-point units per frame.
REQ-004 Parameter INITIAL_Y_SPEED, default 20, meaning initial Y speed in fixed-point units per frame.
REQ-005 Parameter Y_ACCEL, default 1, meaning per-frame Y speed increment (gravity).
REQ-006 Parameter MAX_Y_SPEED, default 230, meaning Y speed magnitude limit.
REQ-007 Parameter JUMP_SPEED, default 200, meaning upward speed magnitude on jump.
REQ-008 clk  input  1  system clock.
REQ-009 resetN  input  1  reset, asynchronous, active-low.
REQ-010 startOfFrame  input  1  one-cycle pulse per VGA frame.
REQ-011 collision  input  1  level; object overlaps another object on the current pixel.
REQ-012 HitEdgeCode  input  4  edge of object touched: bit3 left, bit2 top, bit1 right, bit0 bottom.
REQ-013 jumpKey  input  1  level; jump request.
REQ-014 topLeftX  output  11 signed  object top-left X in pixels, feeds square_object.
REQ-015 topLeftY  output  11 signed  object top-left Y in pixels, feeds square_object.

Function
REQ-016 Positions and speeds SHALL be held as 32-bit signed integers in fixed point with 6 fractional bits (multiplier 64).
REQ-017 On any cycle where collision=1, each bit of HitEdgeCode SHALL be ORed into a 4-bit hit latch.
REQ-018 The FSM SHALL have states IDLE, BOUNCE, ACCEL, POSITION and OUTPUT, each non-IDLE state lasting exactly one cycle.
REQ-019 IDLE SHALL move to BOUNCE on startOfFrame=1; otherwise it SHALL remain in IDLE.
REQ-020 startOfFrame while not in IDLE SHALL be ignored.
REQ-021 BOUNCE: left hit with Xspeed<0 or right hit with Xspeed>0 SHALL negate Xspeed.
REQ-022 BOUNCE: top hit with Yspeed<0 or bottom hit with Yspeed>0 SHALL negate Yspeed.
REQ-023 BOUNCE SHALL clear the hit latch, except that a collision in the same cycle SHALL win, so that its bits survive for the next frame.
REQ-024 ACCEL: if jumpKey=1, Yspeed SHALL be set to -JUMP_SPEED; otherwise Yspeed += Y_ACCEL, saturated to [-MAX_Y_SPEED, +MAX_Y_SPEED].
REQ-025 POSITION: posX += Xspeed and posY += Yspeed, with no wrap protection required.
REQ-026 OUTPUT: topLeftX/Y SHALL take pos arithmetically shifted right by 6 (floor), truncated to 11 bits signed; the FSM then returns to IDLE.
REQ-027 topLeftX/Y SHALL be registered and change only in OUTPUT, exactly 4 cycles after the startOfFrame pulse.
REQ-028 Simultaneous hits on opposite edges SHALL each be evaluated independently against the speed sign.

Reset
REQ-029 resetN=0 SHALL immediately, in any state, set the state to IDLE and clear the hit latch.
REQ-030 resetN=0 SHALL set posX=INITIAL_X*64, posY=INITIAL_Y*64, Xspeed=INITIAL_X_SPEED and Yspeed=INITIAL_Y_SPEED.
REQ-031 resetN=0 SHALL set topLeftX=INITIAL_X and topLeftY=INITIAL_Y.

Structure
REQ-032 A shared package object_pkg SHALL hold the FSM state enum, HitEdgeCode bit-index constants and FIXED_POINT_SHIFT=6.
REQ-033 The block SHALL be a single module with no sub-module; the hit latch and FSM are inline.

Verification
REQ-034 Reset, then one startOfFrame, no hits -> 4 cycles later topLeftX=280 (posX 17960) and topLeftY=185 (posY 11861, Yspeed 21).
REQ-035 Second frame, no hits -> topLeftX=281 (posX 18000).
REQ-036 collision=1 with HitEdgeCode=4'b0010 for one cycle mid-frame, Xspeed=40 -> next frame Xspeed=-40 and posX decreases by 40; a left hit with Xspeed=-40 -> no change.
REQ-037 No hits for 300 frames -> Yspeed stops at 230 and never exceeds it; jumpKey=1 at a frame -> Yspeed=-200 that frame, -199 the next frame with jumpKey=0.
REQ-038 Collision coincident with BOUNCE -> hit applied in the following frame, not lost.
REQ-039 resetN pulsed low during POSITION -> outputs return to 280/185 asynchronously, and the next startOfFrame repeats the REQ-034 result.
